// File: rtl/fm_mem_port_ctrl.sv
`timescale 1ns/1ps
// Control for one semi-true dual-port feature-map memory: round-robin sharing of
// read/write port A among NUM_REQ requesters, plus a burst-read sequencer on port B.
module fm_mem_port_ctrl #(
    parameter int BIT_LENGTH = 64,
    parameter int DEPTH      = 16,
    parameter int NUM_REQ    = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*BIT_LENGTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [BIT_LENGTH-1:0]         rsp_rdata,
    input  logic                          rd_start,
    input  logic [AW-1:0]                 rd_base,
    input  logic [AW:0]                   rd_len,
    output logic                          rd_busy,
    output logic                          rd_valid,
    output logic [BIT_LENGTH-1:0]         rd_data,
    output logic                          rd_done,
    output logic [AW-1:0]                 mem_addra,
    output logic [BIT_LENGTH-1:0]         mem_dina,
    output logic                          mem_ena,
    output logic                          mem_wea,
    input  logic [BIT_LENGTH-1:0]         mem_douta,
    output logic [AW-1:0]                 mem_addrb,
    output logic                          mem_enb,
    input  logic [BIT_LENGTH-1:0]         mem_doutb
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} seq_state_t;

    seq_state_t            state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         win;
    logic [PW-1:0]         ptr_nxt;
    logic                  found;
    int                    cand;
    logic [NUM_REQ-1:0]    grant;
    logic                  win_we;
    logic [AW-1:0]         win_addr;
    logic [BIT_LENGTH-1:0] win_wdata;
    logic [AW-1:0]         addr;
    logic [AW:0]           remaining;
    logic                  stall;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[PW'(cand)]) begin
                found = 1'b1;
                win   = PW'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) grant[win] = 1'b1;
    end

    assign win_we    = req_we[win];
    assign win_addr  = req_addr[int'(win)*AW +: AW];
    assign win_wdata = req_wdata[int'(win)*BIT_LENGTH +: BIT_LENGTH];
    assign ptr_nxt   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

    assign req_ready = grant;
    assign mem_ena   = found;
    assign mem_wea   = found & win_we;
    assign mem_addra = found ? win_addr : '0;
    assign mem_dina  = found ? win_wdata : '0;

    // Port A always wins a same-address collision; the burst simply retries next cycle.
    assign stall     = (state == S_RUN) && found && win_we && (win_addr == addr);
    assign mem_enb   = (state == S_RUN) && !stall;
    assign mem_addrb = (state == S_RUN) ? addr : '0;
    assign rd_busy   = (state != S_IDLE);

    assign rsp_rdata = (|rsp_valid) ? mem_douta : '0;
    assign rd_data   = rd_valid ? mem_doutb : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            addr      <= '0;
            remaining <= '0;
            rsp_valid <= '0;
            rd_valid  <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            if (found) ptr <= ptr_nxt;
            rsp_valid <= (found && !win_we) ? grant : '0;
            rd_valid  <= mem_enb;
            rd_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        if (rd_len == '0) begin
                            state   <= S_DONE;
                            rd_done <= 1'b1;
                        end else begin
                            addr      <= rd_base;
                            remaining <= rd_len;
                            state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        addr      <= addr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        // rd_done lines up with the data of the last issued word.
                        if (remaining == (AW+1)'(1)) begin
                            state   <= S_DRAIN;
                            rd_done <= 1'b1;
                        end
                    end
                end
                S_DRAIN: state <= S_IDLE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fm_mem_port_ctrl.md
Name: fm_mem_port_ctrl

Overview:
- Sequences and shares one semi-true dual-port feature-map/gradient memory (port A read/write in "no change" mode, port B read-only, 1-cycle read latency on both ports).
- Port A is shared round-robin among NUM_REQ requesters, e.g. forward fm writer and backward gd read/modify path.
- Port B is driven by an internal burst-read sequencer that streams a contiguous address range to a consumer.
- Sits between the layer engines and the memory instance; all memory control is owned here.

Parameters:
- BIT_LENGTH, 64, data word width.
- DEPTH, 16, memory depth in words. AW = $clog2(DEPTH).
- NUM_REQ, 2, number of port-A requesters (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*BIT_LENGTH  packed write data
- req_ready  out  NUM_REQ  one-hot grant; access accepted when valid&ready
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  BIT_LENGTH  read data, shared by all requesters
- rd_start  in  1  start burst (accepted only in IDLE)
- rd_base  in  AW  burst start address
- rd_len  in  AW+1  burst word count (0..DEPTH)
- rd_busy  out  1  sequencer not IDLE
- rd_valid  out  1  burst data valid
- rd_data  out  BIT_LENGTH  burst data
- rd_done  out  1  one-cycle pulse at end of burst
- mem_addra  out  AW
- mem_dina  out  BIT_LENGTH
- mem_ena  out  1
- mem_wea  out  1
- mem_douta  in  BIT_LENGTH
- mem_addrb  out  AW
- mem_enb  out  1
- mem_doutb  in  BIT_LENGTH

Behaviour:
- Reset (async assert, sync release):
  - RR pointer = 0; rsp_valid = 0; rd_valid = 0; rd_done = 0; rd_busy = 0; sequencer IDLE.
  - In-flight read responses are dropped; no response or rd_valid appears after reset.
- Port A arbitration:
  - Winner is the first valid requester at or after the pointer, searching upward with wrap. The decision is combinational.
  - req_ready is asserted for the winner only, in the same cycle.
  - req_ready is never asserted without req_valid.
  - No valid requests: mem_ena = 0 and req_ready = 0.
  - On grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - A sole continuously valid requester is granted every cycle.
- Port A drive:
  - mem_ena = any grant; mem_wea = req_we of winner.
  - mem_addra / mem_dina = winner's fields, combinational.
- Read response:
  - For an accepted read by requester i, rsp_valid[i] = 1 exactly one cycle later, with rsp_rdata = mem_douta.
  - Writes produce no response.
  - rsp_valid is at most one-hot. Back-to-back reads give back-to-back responses.
- Burst sequencer FSM:
  - IDLE: on rd_start with rd_len = 0, go to DONE with no memory access. On rd_start with rd_len > 0, latch addr = rd_base and remaining = rd_len, then go to RUN.
  - RUN: each non-stalled cycle, mem_enb = 1, mem_addrb = addr, addr = addr + 1 (wraps mod 2^AW), remaining decrements. When the last word issues, go to DRAIN.
  - DRAIN: one cycle, then go to IDLE. rd_done pulses together with the last rd_valid.
  - DONE (len 0 only): rd_done pulses one cycle, then go to IDLE.
  - rd_valid is asserted one cycle after each mem_enb issue, with rd_data = mem_doutb.
  - rd_busy = 1 in RUN, DRAIN and DONE.
  - rd_start outside IDLE is ignored.
- Conflict stall:
  - In RUN, if port A is granted a write this cycle with mem_addra == addr, port B stalls.
  - On a stall: mem_enb = 0, address and count are held, and port A is never stalled.
- mem_enb = 0 outside RUN.

Test Plan:
- Single requester 0 writes 0xA5 to addr 3, then reads addr 3 → req_ready[0] = 1 both cycles; rsp_valid[0] = 1 one cycle after the read with rsp_rdata = 0xA5; no response for the write.
- Both requesters hold req_valid = 1 for 4 cycles from reset → grants alternate 0, 1, 0, 1; never both ready.
- Burst rd_base = 14, rd_len = 4, DEPTH = 16, memory preloaded with data = addr → mem_addrb issues 14, 15, 0, 1; rd_data 14, 15, 0, 1 on consecutive cycles; rd_done coincides with data 1; rd_busy drops the next cycle.
- During RUN with addr = 5, requester 1 writes 0x77 to addr 5 → mem_enb = 0 that cycle; the next cycle reads addr 5; rd_data for addr 5 = 0x77.
- rd_len = 0 → no mem_enb; rd_done pulses one cycle after rd_start. A second rd_start while busy is ignored.
- rst_n low in the cycle after an accepted read and mid-burst → no rsp_valid or rd_valid ever appears; all outputs 0; pointer restarts at requester 0.
